dma_kopiowanie_stron: RTL and testbench

//  Initiator side of the paged data-memory port: block-copy engine moving len words from physical src to dst.

---
 rtl/dma_kopiowanie_pkg.sv | 20 ++
 rtl/dma_kopiowanie_stron_inkrement.sv | 28 ++
 rtl/dma_kopiowanie_stron.sv | 188 ++++++++++++++++++
 tb/tb_dma_kopiowanie_stron.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_kopiowanie_pkg.sv
// Shared constants for the paged block-copy engine: FSM state encodings and
// the reserved offsets of the paged memory port.
package dma_kopiowanie_pkg;

    typedef logic [2:0] stan_t;

    localparam stan_t ST_IDLE    = 3'd0;
    localparam stan_t ST_SAVE    = 3'd1;
    localparam stan_t ST_SET_SRC = 3'd2;
    localparam stan_t ST_READ    = 3'd3;
    localparam stan_t ST_SET_DST = 3'd4;
    localparam stan_t ST_WRITE   = 3'd5;
    localparam stan_t ST_RESTORE = 3'd6;
    localparam stan_t ST_DONE    = 3'd7;

    // Offsets for the default 8-bit offset width.
    localparam logic [7:0] PAGE_REG_OFF = 8'hFF;
    localparam logic [7:0] MAX_OFF      = 8'hFE;

endpackage

// File: rtl/dma_kopiowanie_stron_inkrement.sv
// Advances a physical {page, offset} address by one word, skipping the page
// register offset and wrapping the page number modulo 2^S.
module inkrement_adresu_stron #(
    parameter int S = 4,
    parameter int A = 8
) (
    input  logic [S+A-1:0] adr_i,
    output logic [S+A-1:0] adr_o
);

    localparam logic [A-1:0] MAX_OFF_L = {{(A-1){1'b1}}, 1'b0};
    localparam logic [A-1:0] OFF_ONE   = 1;
    localparam logic [S-1:0] PAGE_ONE  = 1;

    logic [S-1:0] page;
    logic [A-1:0] off;

    always_comb begin
        page = adr_i[S+A-1:A];
        off  = adr_i[A-1:0];
        if (off >= MAX_OFF_L) begin
            adr_o = {page + PAGE_ONE, {A{1'b0}}};
        end else begin
            adr_o = {page, off + OFF_ONE};
        end
    end

endmodule

// File: rtl/dma_kopiowanie_stron.sv
// Block-copy engine on the paged data-memory port: copies len words from src
// to dst, reprogramming the page register as needed and restoring it on exit.
module dma_kopiowanie_stron
    import dma_kopiowanie_pkg::*;
#(
    parameter int ADDR_WIDTH_MEM    = 8,
    parameter int DATA_WIDTH_MEM    = 8,
    parameter int DATA_WIDTH_STRONY = 4,
    parameter int LEN_WIDTH         = 12
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] src_adr,
    input  logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] dst_adr,
    input  logic [LEN_WIDTH-1:0]                        len,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err,
    output logic                                        wr_mem,
    output logic [ADDR_WIDTH_MEM-1:0]                   adres,
    output logic [DATA_WIDTH_MEM-1:0]                   dane,
    input  logic [DATA_WIDTH_MEM-1:0]                   mem_out
);

    localparam int A = ADDR_WIDTH_MEM;
    localparam int S = DATA_WIDTH_STRONY;
    localparam int D = DATA_WIDTH_MEM;
    localparam int L = LEN_WIDTH;

    localparam logic [A-1:0] PG_OFF  = '1;
    localparam logic [L-1:0] LEN_ONE = 1;

    stan_t          state_q, state_d;
    logic [S+A-1:0] src_q, src_d, dst_q, dst_d;
    logic [S+A-1:0] src_nxt, dst_nxt;
    logic [L-1:0]   len_q, len_d;
    logic [D-1:0]   buf_q, buf_d;
    logic [S-1:0]   saved_q, saved_d;
    logic [S-1:0]   cache_q, cache_d;
    logic           vld_q, vld_d;
    logic           err_q, err_d;

    inkrement_adresu_stron #(.S(S), .A(A)) u_inc_src (.adr_i(src_q), .adr_o(src_nxt));
    inkrement_adresu_stron #(.S(S), .A(A)) u_inc_dst (.adr_i(dst_q), .adr_o(dst_nxt));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        buf_d   = buf_q;
        saved_d = saved_q;
        cache_d = cache_q;
        vld_d   = vld_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_adr;
                    dst_d = dst_adr;
                    len_d = len;
                    err_d = 1'b0;
                    if (src_adr[A-1:0] == PG_OFF || dst_adr[A-1:0] == PG_OFF) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SAVE;
                    end
                end
            end
            ST_SAVE: begin
                // Reading offset 255 returns the CPU's current page.
                saved_d = mem_out[S-1:0];
                cache_d = mem_out[S-1:0];
                vld_d   = 1'b1;
                state_d = (mem_out[S-1:0] != src_q[S+A-1:A]) ? ST_SET_SRC : ST_READ;
            end
            ST_SET_SRC: begin
                cache_d = src_q[S+A-1:A];
                state_d = ST_READ;
            end
            ST_READ: begin
                buf_d   = mem_out;
                state_d = (!vld_q || cache_q != dst_q[S+A-1:A]) ? ST_SET_DST : ST_WRITE;
            end
            ST_SET_DST: begin
                cache_d = dst_q[S+A-1:A];
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                src_d = src_nxt;
                dst_d = dst_nxt;
                len_d = len_q - LEN_ONE;
                if (len_q == LEN_ONE) begin
                    state_d = ST_RESTORE;
                end else begin
                    state_d = (!vld_q || cache_q != src_nxt[S+A-1:A]) ? ST_SET_SRC : ST_READ;
                end
            end
            ST_RESTORE: begin
                cache_d = saved_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        wr_mem = 1'b0;
        adres  = '0;
        dane   = '0;
        case (state_q)
            ST_SAVE: begin
                busy  = 1'b1;
                adres = PG_OFF;
            end
            ST_SET_SRC: begin
                busy         = 1'b1;
                wr_mem       = 1'b1;
                adres        = PG_OFF;
                dane[S-1:0]  = src_q[S+A-1:A];
            end
            ST_READ: begin
                busy  = 1'b1;
                adres = src_q[A-1:0];
            end
            ST_SET_DST: begin
                busy         = 1'b1;
                wr_mem       = 1'b1;
                adres        = PG_OFF;
                dane[S-1:0]  = dst_q[S+A-1:A];
            end
            ST_WRITE: begin
                busy   = 1'b1;
                wr_mem = 1'b1;
                adres  = dst_q[A-1:0];
                dane   = buf_q;
            end
            ST_RESTORE: begin
                // Skip the write when the CPU's page is already selected.
                busy         = 1'b1;
                wr_mem       = (cache_q != saved_q);
                adres        = PG_OFF;
                dane[S-1:0]  = saved_q;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            saved_q <= '0;
            cache_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            saved_q <= saved_d;
            cache_q <= cache_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dma_kopiowanie_stron.sv
// Bench for the paged block-copy engine: a paged memory model on a muxed port,
// expected write/done queues and a negedge monitor that pops and compares.
module tb_dma_kopiowanie_stron;
    import dma_kopiowanie_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] src_adr, dst_adr, len;
    logic        busy, done, err, wr_mem;
    logic [7:0]  adres, dane, mem_out;

    always #5 clk = ~clk;

    dma_kopiowanie_stron #(
        .ADDR_WIDTH_MEM(8), .DATA_WIDTH_MEM(8), .DATA_WIDTH_STRONY(4), .LEN_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
        .len(len), .busy(busy), .done(done), .err(err), .wr_mem(wr_mem),
        .adres(adres), .dane(dane), .mem_out(mem_out)
    );

    function automatic logic [7:0] iv(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    function automatic logic [20:0] ew_page(input logic [3:0] p);
        return {1'b1, 12'h000, 4'h0, p};
    endfunction

    function automatic logic [20:0] ew_data(input logic [11:0] a, input logic [7:0] d);
        return {1'b0, a, d};
    endfunction

    // pamiec_data: paged memory, CPU owns the port while busy=0
    logic [7:0] pamiec_data [0:4095];
    logic [3:0] page_reg;
    logic       init_mem, cpu_wr;
    logic [7:0] cpu_adres, cpu_dane;
    logic       port_wr;
    logic [7:0] port_adres, port_dane;

    assign port_wr    = busy ? wr_mem : cpu_wr;
    assign port_adres = busy ? adres  : cpu_adres;
    assign port_dane  = busy ? dane   : cpu_dane;
    assign mem_out    = (port_adres == PAGE_REG_OFF) ? {4'h0, page_reg}
                                                     : pamiec_data[{page_reg, port_adres}];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) pamiec_data[i] <= iv(12'(i));
            page_reg <= 4'h0;
        end else if (port_wr) begin
            if (port_adres == PAGE_REG_OFF) page_reg <= port_dane[3:0];
            else pamiec_data[{page_reg, port_adres}] <= port_dane;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [20:0] exp_q[$];
    logic [8:0]  exp_done_q[$];
    int          start_cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, a, e);
        end
    endtask

    task automatic monitor_loop;
        logic [20:0] act_w, e_w;
        logic [8:0]  act_d, e_d;
        forever begin
            @(negedge clk);
            if (wr_mem) begin
                act_w = (adres == PAGE_REG_OFF) ? {1'b1, 12'h000, dane} : {1'b0, page_reg, adres, dane};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got %h, required no write", act_w);
                end else begin
                    e_w = exp_q.pop_front();
                    chk("wr_event", 32'(act_w), 32'(e_w));
                end
            end
            if (done) begin
                act_d = {err, 8'(cyc - start_cyc)};
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got %h, required no done", act_d);
                end else begin
                    e_d = exp_done_q.pop_front();
                    chk("done_err_lat", 32'(act_d), 32'(e_d));
                end
            end
        end
    endtask

    task automatic cpu_page(input logic [3:0] p);
        cpu_wr    = 1'b1;
        cpu_adres = PAGE_REG_OFF;
        cpu_dane  = {4'h0, p};
        tick();
        cpu_wr    = 1'b0;
    endtask

    task automatic issue(input logic [11:0] s, input logic [11:0] d, input logic [11:0] l);
        src_adr   = s;
        dst_adr   = d;
        len       = l;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 60 && exp_done_q.size() != 0; i++) tick();
        checks++;
        if (exp_done_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got no done, required done", nm);
            exp_done_q.delete();
        end
        tick();
        chk({nm, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; init_mem = 1'b1; start = 1'b0; cpu_wr = 1'b0;
        cpu_adres = 8'h00; cpu_dane = 8'h00;
        src_adr = '0; dst_adr = '0; len = '0;
        fork
            monitor_loop();
        join_none
        repeat (3) tick();
        init_mem = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_mem", wr_mem, 0);
        chk("rst_adres", adres, 0);
        chk("rst_dane", dane, 0);
        rst = 1'b0;
        tick();

        // same page: no page writes, done 9 cycles after start
        cpu_page(4'h2);
        exp_q.push_back(ew_data(12'h220, iv(12'h210)));
        exp_q.push_back(ew_data(12'h221, iv(12'h211)));
        exp_q.push_back(ew_data(12'h222, iv(12'h212)));
        exp_done_q.push_back({1'b0, 8'd9});
        issue(12'h210, 12'h220, 12'd3);
        wait_done("same_page");
        chk("same_page_pg", page_reg, 4'h2);
        chk("same_page_mem", pamiec_data[12'h222], iv(12'h212));

        // cross page, single word
        cpu_page(4'h0);
        exp_q.push_back(ew_page(4'h1));
        exp_q.push_back(ew_page(4'h3));
        exp_q.push_back(ew_data(12'h307, iv(12'h105)));
        exp_q.push_back(ew_page(4'h0));
        exp_done_q.push_back({1'b0, 8'd7});
        issue(12'h105, 12'h307, 12'd1);
        wait_done("cross_page");
        chk("cross_page_pg", page_reg, 4'h0);

        // source crosses offset 254 -> next page offset 0
        exp_q.push_back(ew_page(4'h1));
        exp_q.push_back(ew_page(4'h4));
        exp_q.push_back(ew_data(12'h410, iv(12'h1FD)));
        exp_q.push_back(ew_page(4'h1));
        exp_q.push_back(ew_page(4'h4));
        exp_q.push_back(ew_data(12'h411, iv(12'h1FE)));
        exp_q.push_back(ew_page(4'h2));
        exp_q.push_back(ew_page(4'h4));
        exp_q.push_back(ew_data(12'h412, iv(12'h200)));
        exp_q.push_back(ew_page(4'h0));
        exp_done_q.push_back({1'b0, 8'd15});
        issue(12'h1FD, 12'h410, 12'd3);
        wait_done("off_skip");
        chk("off_skip_pg", page_reg, 4'h0);
        chk("off_skip_412", pamiec_data[12'h412], iv(12'h200));

        // destination wraps from page F to page 0; restore write skipped
        exp_q.push_back(ew_page(4'h5));
        exp_q.push_back(ew_page(4'hF));
        exp_q.push_back(ew_data(12'hFFE, iv(12'h530)));
        exp_q.push_back(ew_page(4'h5));
        exp_q.push_back(ew_page(4'h0));
        exp_q.push_back(ew_data(12'h000, iv(12'h531)));
        exp_done_q.push_back({1'b0, 8'd11});
        issue(12'h530, 12'hFFE, 12'd2);
        wait_done("page_wrap");
        chk("page_wrap_000", pamiec_data[12'h000], iv(12'h531));
        chk("page_wrap_pg", page_reg, 4'h0);

        // rejected requests and empty copy
        exp_done_q.push_back({1'b1, 8'd1});
        issue(12'h2FF, 12'h100, 12'd5);
        wait_done("err_src");
        exp_done_q.push_back({1'b1, 8'd1});
        issue(12'h100, 12'h3FF, 12'd1);
        wait_done("err_dst");
        exp_done_q.push_back({1'b0, 8'd1});
        issue(12'h100, 12'h200, 12'd0);
        wait_done("len_zero");
        chk("len_zero_mem", pamiec_data[12'h200], iv(12'h200));

        // start while busy ignored; reset during second WRITE aborts
        cpu_page(4'h2);
        exp_q.push_back(ew_data(12'h240, iv(12'h230)));
        exp_q.push_back(ew_data(12'h241, iv(12'h231)));
        issue(12'h230, 12'h240, 12'd4);
        tick();
        src_adr = 12'h2FF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        chk("abort_at_write", {wr_mem, adres}, {1'b1, 8'h41});
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_wr_mem", wr_mem, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_writes_left", exp_q.size(), 0);
        chk("abort_mem_242", pamiec_data[12'h242], iv(12'h242));
        chk("final_done_left", exp_done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
